// File: rtl/reset_clock_dmem_if.sv
// ---------------------------------------------------------------------------
// reset_clock_dmem_if
//   Data-memory bus between the processor and the reset/clock/dmem
//   infrastructure block.
//   Signals:
//     address_dmem  ADDR_W  word address (processor -> memory)
//     data          DATA_W  write data   (processor -> memory)
//     wren          1       write enable (processor -> memory)
//     q_dmem        DATA_W  registered read data (memory -> processor)
//   Modports:
//     master  processor side
//     slave   memory side
// ---------------------------------------------------------------------------
interface reset_clock_dmem_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  q_dmem
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output q_dmem
    );
endinterface

// File: rtl/reset_clock_dmem.sv
// ---------------------------------------------------------------------------
// reset_clock_dmem
//   Tetris SoC infrastructure: power-on reset stretcher, clock-enable style
//   stand-in for the VGA/audio PLL, and the single-port processor data memory.
//   Ports:
//     clock         in   system clock (50 MHz)
//     reset_n       in   synchronous active-low reset
//     dmem          if   data-memory bus (slave modport)
//     dly_rst_n     out  delayed reset, high DELAY_CYCLES+1 cycles after release
//     pll_locked    out  dly_rst_n delayed by one cycle
//     vga_ctrl_clk  out  clock/2 square wave, starts high the cycle after lock
//     vga_clk       out  complement of vga_ctrl_clk
//     aud_ctrl_clk  out  MSB of a 32-bit NCO (~18.432 MHz average)
// ---------------------------------------------------------------------------
module reset_clock_dmem #(
    parameter int unsigned DELAY_CYCLES = 1048575,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter logic [31:0] AUD_STEP     = 32'd1583296744
) (
    input  logic                    clock,
    input  logic                    reset_n,
    reset_clock_dmem_if.slave       dmem,
    output logic                    dly_rst_n,
    output logic                    pll_locked,
    output logic                    vga_ctrl_clk,
    output logic                    vga_clk,
    output logic                    aud_ctrl_clk
);

    localparam int unsigned CNT_W = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(DELAY_CYCLES);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [CNT_W-1:0]  dly_cnt;
    logic [31:0]       acc;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Reset stretcher: counter saturates at DELAY_MAX, dly_rst_n rises the
    // edge after saturation is observed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dly_cnt   <= '0;
            dly_rst_n <= 1'b0;
        end else if (dly_cnt < DELAY_MAX) begin
            dly_cnt <= dly_cnt + 1'b1;
        end else begin
            dly_rst_n <= 1'b1;
        end
    end

    // Divided clocks are held low while dly_rst_n is low (PLL in reset).
    // vga_clk takes the old vga_ctrl_clk, i.e. the complement of the new one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pll_locked   <= 1'b0;
            vga_ctrl_clk <= 1'b0;
            vga_clk      <= 1'b0;
            acc          <= '0;
        end else begin
            pll_locked <= dly_rst_n;
            if (!dly_rst_n) begin
                vga_ctrl_clk <= 1'b0;
                vga_clk      <= 1'b0;
                acc          <= '0;
            end else begin
                vga_ctrl_clk <= ~vga_ctrl_clk;
                vga_clk      <= vga_ctrl_clk;
                acc          <= acc + AUD_STEP;
            end
        end
    end

    assign aud_ctrl_clk = acc[31];

    // Memory array: no reset so it maps onto block RAM; reset only
    // suppresses the write in that cycle.
    always_ff @(posedge clock) begin
        if (reset_n && dmem.wren) begin
            mem[dmem.address_dmem] <= dmem.data;
        end
    end

    // Registered read returns pre-write contents on read-during-write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dmem.q_dmem <= '0;
        end else begin
            dmem.q_dmem <= mem[dmem.address_dmem];
        end
    end

endmodule

// File: tb/tb_reset_clock_dmem.sv
// ---------------------------------------------------------------------------
// tb_reset_clock_dmem
//   Self-checking bench for reset_clock_dmem with a short reset delay.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. Expected dmem read data is queued when an access is issued and
//   popped when the registered read data appears one cycle later.
// ---------------------------------------------------------------------------
module tb_reset_clock_dmem;

    localparam int unsigned DLY = 16;

    logic clock;
    logic reset_n;
    logic dly_rst_n;
    logic pll_locked;
    logic vga_ctrl_clk;
    logic vga_clk;
    logic aud_ctrl_clk;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    reset_clock_dmem_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    reset_clock_dmem #(
        .DELAY_CYCLES (DLY),
        .ADDR_W       (12),
        .DATA_W       (32),
        .AUD_STEP     (32'd1583296744)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dmem         (bus.slave),
        .dly_rst_n    (dly_rst_n),
        .pll_locked   (pll_locked),
        .vga_ctrl_clk (vga_ctrl_clk),
        .vga_clk      (vga_clk),
        .aud_ctrl_clk (aud_ctrl_clk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk, aud_ctrl_clk} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk, aud_ctrl_clk});
        end
        total++;
        if (bus.q_dmem !== 32'h0) begin
            bad++;
            $display("FAIL reset_q got=%h want=00000000", bus.q_dmem);
        end
    endtask

    // Release reset and follow the lock sequence edge by edge.
    task automatic test_lock();
        int early_hi;
        int clk_early;
        early_hi  = 0;
        clk_early = 0;
        reset_n = 1'b1;
        for (int k = 1; k <= DLY; k++) begin
            @(negedge clock);
            if (dly_rst_n !== 1'b0) early_hi++;
            if (vga_ctrl_clk !== 1'b0 || vga_clk !== 1'b0 || aud_ctrl_clk !== 1'b0) clk_early++;
        end
        total++;
        if (early_hi != 0) begin
            bad++;
            $display("FAIL dly_early got=%0d high cycles want=0", early_hi);
        end
        total++;
        if (clk_early != 0) begin
            bad++;
            $display("FAIL clocks_before_lock got=%0d active cycles want=0", clk_early);
        end
        @(negedge clock);  // edge DLY+1
        total++;
        if ({dly_rst_n, pll_locked, vga_ctrl_clk} !== 3'b100) begin
            bad++;
            $display("FAIL dly_rise got=%b want=100", {dly_rst_n, pll_locked, vga_ctrl_clk});
        end
        @(negedge clock);  // edge DLY+2
        total++;
        if ({dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk} !== 4'b1110) begin
            bad++;
            $display("FAIL first_run_edge got=%b want=1110",
                     {dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk});
        end
    endtask

    task automatic test_vga();
        logic prev_c;
        logic prev_v;
        int   rise_c;
        int   rise_v;
        int   not_comp;
        int   dly_drop;
        prev_c   = vga_ctrl_clk;
        prev_v   = vga_clk;
        rise_c   = 0;
        rise_v   = 0;
        not_comp = 0;
        dly_drop = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (vga_ctrl_clk === 1'b1 && prev_c === 1'b0) rise_c++;
            if (vga_clk === 1'b1 && prev_v === 1'b0) rise_v++;
            if (vga_clk !== ~vga_ctrl_clk || vga_ctrl_clk !== ~prev_c) not_comp++;
            if (dly_rst_n !== 1'b1 || pll_locked !== 1'b1) dly_drop++;
            prev_c = vga_ctrl_clk;
            prev_v = vga_clk;
        end
        total++;
        if (rise_c != 50) begin
            bad++;
            $display("FAIL vga_ctrl_rises got=%0d want=50", rise_c);
        end
        total++;
        if (rise_v != 50) begin
            bad++;
            $display("FAIL vga_clk_rises got=%0d want=50", rise_v);
        end
        total++;
        if (not_comp != 0) begin
            bad++;
            $display("FAIL vga_phase got=%0d bad cycles want=0", not_comp);
        end
        total++;
        if (dly_drop != 0) begin
            bad++;
            $display("FAIL lock_stays got=%0d low cycles want=0", dly_drop);
        end
    endtask

    task automatic test_nco();
        logic prev;
        int   rises;
        prev  = aud_ctrl_clk;
        rises = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            if (aud_ctrl_clk === 1'b1 && prev === 1'b0) rises++;
            prev = aud_ctrl_clk;
        end
        total++;
        if (rises < 3685 || rises > 3687) begin
            bad++;
            $display("FAIL nco_rises got=%0d want=3686+/-1", rises);
        end
    endtask

    // Basic write/read plus the top address; q during the write cycle shows
    // the old (zero) contents.
    task automatic test_dmem();
        logic [11:0] t_addr [5] = '{12'd5, 12'd5, 12'd4095, 12'd4, 12'd5};
        logic [31:0] t_data [5] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        t_we   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_exp  [5] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
        logic [31:0] e;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.q_dmem !== e) begin
                    bad++;
                    $display("FAIL dmem_rd[%0d] got=%h want=%h", i - 1, bus.q_dmem, e);
                end
            end
            if (i < 5) begin
                bus.address_dmem = t_addr[i];
                bus.data         = t_data[i];
                bus.wren         = t_we[i];
                exp_q.push_back(t_exp[i]);
            end else begin
                bus.wren = 1'b0;
            end
        end
    endtask

    // Read-during-write to the same address, then back-to-back mixed traffic.
    task automatic test_back_to_back();
        logic [11:0] t_addr [6] = '{12'd5, 12'd5, 12'd4095, 12'd4095, 12'd0, 12'd5};
        logic [31:0] t_data [6] = '{32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0F0F0F0F, 32'h0};
        logic        t_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_exp  [6] = '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h12345678};
        logic [31:0] e;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.q_dmem !== e) begin
                    bad++;
                    $display("FAIL rdw[%0d] got=%h want=%h", i - 1, bus.q_dmem, e);
                end
            end
            if (i < 6) begin
                bus.address_dmem = t_addr[i];
                bus.data         = t_data[i];
                bus.wren         = t_we[i];
                exp_q.push_back(t_exp[i]);
            end else begin
                bus.wren = 1'b0;
            end
        end
    endtask

    // Reset while running: outputs drop, a write during reset is ignored,
    // memory keeps its data and the delay restarts.
    task automatic test_mid_reset();
        int early_hi;
        @(negedge clock);
        reset_n          = 1'b0;
        bus.address_dmem = 12'd5;
        bus.data         = 32'hFFFFFFFF;
        bus.wren         = 1'b1;
        @(negedge clock);
        total++;
        if ({dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk, aud_ctrl_clk} !== 5'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b want=00000",
                     {dly_rst_n, pll_locked, vga_ctrl_clk, vga_clk, aud_ctrl_clk});
        end
        total++;
        if (bus.q_dmem !== 32'h0) begin
            bad++;
            $display("FAIL midrst_q got=%h want=00000000", bus.q_dmem);
        end
        reset_n  = 1'b1;
        bus.wren = 1'b0;
        exp_q.push_back(32'h12345678);
        early_hi = 0;
        for (int k = 1; k <= DLY; k++) begin
            @(negedge clock);
            if (k == 1) begin
                total++;
                if (bus.q_dmem !== exp_q[0]) begin
                    bad++;
                    $display("FAIL midrst_retain got=%h want=%h", bus.q_dmem, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (dly_rst_n !== 1'b0) early_hi++;
        end
        total++;
        if (early_hi != 0) begin
            bad++;
            $display("FAIL midrst_delay got=%0d high cycles want=0", early_hi);
        end
        @(negedge clock);
        total++;
        if (dly_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL midrst_relock got=%b want=1", dly_rst_n);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lock();
        test_vga();
        test_nco();
        test_dmem();
        test_back_to_back();
        test_mid_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
